eviction_write_buffer: RTL and testbench
========================================

# eviction_write_buffer

Line-granular write buffer between the data cache and the data-side ports of the memory arbiter. It absorbs dirty-line writebacks so the cache sees a 1-cycle write acknowledgement. It merges repeated writebacks to the same line and serves cache reads that hit a buffered line. Buffered lines drain to the arbiter whenever the cache is not waiting on a read.

## Interface
- DEPTH, 4, number of line entries (power of two, ≥2)
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- mem_address  in  32  cache request address; bits [4:0] ignored
- mem_read  in  1  cache line read request, held until mem_resp
- mem_write  in  1  cache line write request, held until mem_resp
- mem_wdata  in  256  line to write (rv32i_line)
- mem_rdata  out  256  line returned to cache, valid while mem_resp=1
- mem_resp  out  1  one-cycle completion pulse to cache
- pmem_address  out  32  line address to arbiter, bits [4:0] always 0
- pmem_read  out  1  read request to arbiter, held until pmem_resp
- pmem_write  out  1  write request to arbiter, held until pmem_resp
- pmem_wdata  out  256  line written to arbiter
- pmem_rdata  in  256  line from arbiter, valid with pmem_resp
- pmem_resp  in  1  one-cycle completion pulse from arbiter
- count  out  $clog2(DEPTH)+1  occupied entries
- empty  out  1  count==0

## Operation
- Storage: circular FIFO of DEPTH entries {valid, tag[31:5], line[255:0]}; head and tail pointers wrap modulo DEPTH; count tracks occupancy.
- Hit: mem_address[31:5] equals the tag of a valid entry. Coalescing guarantees at most one match.
- States: IDLE, FILL, DRAIN, ACK.
- IDLE priority, highest first:
  - mem_read hit: latch entry line into mem_rdata; go to ACK.
  - mem_read miss: go to FILL.
  - mem_write hit: overwrite that entry's line in place (count unchanged); go to ACK.
  - mem_write miss, not full: write at tail, tail+1, count+1; go to ACK.
  - mem_write miss, full: go to DRAIN. The write is retried from IDLE after the drain completes.
  - no request, count>0: go to DRAIN.
  - otherwise stay in IDLE.
- FILL:
  - pmem_read=1, pmem_address={mem_address[31:5],5'b0}.
  - On pmem_resp: latch pmem_rdata into mem_rdata; go to ACK.
- DRAIN:
  - pmem_write=1, pmem_address={head tag,5'b0}, pmem_wdata=head line.
  - On pmem_resp: clear head valid, head+1, count−1; go to IDLE.
- ACK: mem_resp=1 for exactly one cycle; go to IDLE.
- Simultaneous mem_read and mem_write (protocol violation): the read is served; the write waits.
- Requests arriving while in DRAIN or FILL wait. An arbiter transaction is never aborted.
- Only a miss leaves the buffer for memory. A hit read never produces a pmem transaction, so a read never returns data older than a buffered write.

## Timing
- Reset values: state IDLE, count 0, all valid 0, head=tail=0, empty 1; mem_resp, pmem_read, pmem_write 0; pmem_address 0, pmem_wdata 0, mem_rdata 0.
- Reset asserted mid-FILL/DRAIN: the pmem request drops in the next cycle; buffered contents are discarded.
- All outputs are registered or decoded from the state register; no combinational path from mem_* to pmem_*.
- Write accept: request seen in IDLE at cycle T; mem_resp at T+1.
- Read hit: mem_resp at T+1.
- Read miss: pmem_read rises at T+1. If pmem_resp arrives at cycle R, mem_resp is at R+1.
- Drain: pmem_write rises the cycle after IDLE decides to drain. Entry is popped at the pmem_resp edge; the next drain decision is one cycle later.
- pmem_address, pmem_wdata and pmem_read/pmem_write stay stable from assertion until the pmem_resp cycle inclusive. Both requests drop in the cycle after pmem_resp.
- The cache drops its request in the cycle after mem_resp, so IDLE never re-sees a completed request.

## Test plan
- Reset, then cache write addr 0x0000_1040, data A: mem_resp 1 cycle later, count=1. The next idle cycle starts DRAIN with pmem_address 0x0000_1040 and pmem_wdata A. After pmem_resp, count=0 and empty=1.
- Write 0x100, then write 0x11F with data B while the arbiter stalls pmem_resp: count stays 1 (coalesced). The drain writes B.
- Write 0x200 data C, then read 0x200 before the drain: mem_rdata=C at T+1, and no pmem_read is issued.
- Hold pmem_resp low, write 5 distinct lines with DEPTH=4: the first 4 ack at T+1. The 5th ack is delayed until the first drain completes, and count never exceeds 4. Drain order follows write order, including after pointer wrap.
- Buffer holding 0x300, read miss 0x400 with the arbiter returning D after 3 cycles: pmem_read is held for 3 cycles with address 0x400, and mem_resp with D arrives 1 cycle after pmem_resp.
- Assert rst during DRAIN: pmem_write=0 in the next cycle, count=0, state IDLE.

Source files
------------

// File: rtl/eviction_write_buffer.sv
// Line-granular eviction write buffer between the data cache and the memory arbiter.
// Absorbs dirty-line writebacks, coalesces same-line writes and serves read hits from buffered lines.
module eviction_write_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            mem_address,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [255:0]           mem_wdata,
  output logic [255:0]           mem_rdata,
  output logic                   mem_resp,
  output logic [31:0]            pmem_address,
  output logic                   pmem_read,
  output logic                   pmem_write,
  output logic [255:0]           pmem_wdata,
  input  logic [255:0]           pmem_rdata,
  input  logic                   pmem_resp,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2,
    S_ACK   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [26:0]        tag_q  [DEPTH];
  logic [26:0]        tag_d  [DEPTH];
  logic [255:0]       line_q [DEPTH];
  logic [255:0]       line_d [DEPTH];
  logic [255:0]       mem_rdata_q, mem_rdata_d;
  logic [255:0]       pmem_wdata_q, pmem_wdata_d;
  logic [31:0]        pmem_address_q, pmem_address_d;

  logic [26:0]        req_tag_s;
  logic [DEPTH-1:0]   hit_vec_s;
  logic               hit_s;
  logic [PTR_W-1:0]   hit_idx_s;
  logic               full_s;
  logic               unused_s;

  assign req_tag_s = mem_address[31:5];
  assign unused_s  = ^mem_address[4:0];
  assign hit_s     = |hit_vec_s;
  assign full_s    = (count_q == CNT_FULL);

  // Tag match across valid entries; coalescing keeps the match one-hot, so OR-encoding is exact.
  always_comb begin
    hit_vec_s = '0;
    hit_idx_s = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      hit_vec_s[i] = valid_q[i] && (tag_q[i] == req_tag_s);
      hit_idx_s    = hit_idx_s | (hit_vec_s[i] ? PTR_W'(i) : '0);
    end
  end

  // Next-state and datapath: request arbitration in IDLE, arbiter handshakes in FILL/DRAIN.
  always_comb begin
    state_d        = state_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    valid_d        = valid_q;
    tag_d          = tag_q;
    line_d         = line_q;
    mem_rdata_d    = mem_rdata_q;
    pmem_wdata_d   = pmem_wdata_q;
    pmem_address_d = pmem_address_q;

    case (state_q)
      S_IDLE: begin
        if (mem_read) begin
          if (hit_s) begin
            mem_rdata_d = line_q[hit_idx_s];
            state_d     = S_ACK;
          end else begin
            pmem_address_d = {req_tag_s, 5'd0};
            state_d        = S_FILL;
          end
        end else if (mem_write) begin
          if (hit_s) begin
            line_d[hit_idx_s] = mem_wdata;
            state_d           = S_ACK;
          end else if (!full_s) begin
            valid_d[tail_q] = 1'b1;
            tag_d[tail_q]   = req_tag_s;
            line_d[tail_q]  = mem_wdata;
            tail_d          = tail_q + PTR_ONE;
            count_d         = count_q + CNT_ONE;
            state_d         = S_ACK;
          end else begin
            // Full: make room first; the cache keeps the write asserted and IDLE retries it.
            pmem_address_d = {tag_q[head_q], 5'd0};
            pmem_wdata_d   = line_q[head_q];
            state_d        = S_DRAIN;
          end
        end else if (count_q != '0) begin
          pmem_address_d = {tag_q[head_q], 5'd0};
          pmem_wdata_d   = line_q[head_q];
          state_d        = S_DRAIN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_FILL: begin
        if (pmem_resp) begin
          mem_rdata_d = pmem_rdata;
          state_d     = S_ACK;
        end else begin
          state_d = S_FILL;
        end
      end

      S_DRAIN: begin
        if (pmem_resp) begin
          valid_d[head_q] = 1'b0;
          head_d          = head_q + PTR_ONE;
          count_d         = count_q - CNT_ONE;
          state_d         = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end

      S_ACK: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, storage and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      valid_q        <= '0;
      mem_rdata_q    <= '0;
      pmem_wdata_q   <= '0;
      pmem_address_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        tag_q[i]  <= '0;
        line_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      valid_q        <= valid_d;
      mem_rdata_q    <= mem_rdata_d;
      pmem_wdata_q   <= pmem_wdata_d;
      pmem_address_q <= pmem_address_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        tag_q[i]  <= tag_d[i];
        line_q[i] <= line_d[i];
      end
    end
  end

  assign mem_resp     = (state_q == S_ACK);
  assign pmem_read    = (state_q == S_FILL);
  assign pmem_write   = (state_q == S_DRAIN);
  assign mem_rdata    = mem_rdata_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;
  assign count        = count_q;
  assign empty        = (count_q == '0);

endmodule

// File: tb/tb_eviction_write_buffer.sv
// Directed bench for eviction_write_buffer: per-cycle vector table plus hand-written corner sequences.
module tb_eviction_write_buffer;

  logic         clk;
  logic         rst;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [2:0]   count;
  logic         empty;

  int n_vec  = 0;
  int n_miss = 0;

  eviction_write_buffer #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_address  (mem_address),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .count        (count),
    .empty        (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {rst, mem_read, mem_write}; ex = {mem_resp, pmem_read, pmem_write}
  typedef struct packed {
    logic [2:0]  ctl;
    logic [31:0] addr;
    logic [7:0]  wd;
    logic        presp;
    logic [7:0]  prd;
    logic [2:0]  ex;
    logic [31:0] e_paddr;
    logic [7:0]  e_dat;
    logic        chk_dat;
    logic [2:0]  e_cnt;
  } vec_t;

  localparam logic [2:0] NO = 3'b000, WR = 3'b001, RD = 3'b010, RS = 3'b100;
  localparam logic [2:0] E0 = 3'b000, ER = 3'b100, EP = 3'b010, EW = 3'b001;

  vec_t vq[$];

  function automatic logic [255:0] ln(input logic [7:0] b);
    return {32{b}};
  endfunction

  function automatic vec_t mk(input logic [2:0] ctl, input logic [31:0] addr, input logic [7:0] wd,
                              input logic presp, input logic [7:0] prd, input logic [2:0] ex,
                              input logic [31:0] e_paddr, input logic [7:0] e_dat, input logic chk_dat,
                              input logic [2:0] e_cnt);
    vec_t v;
    v.ctl = ctl; v.addr = addr; v.wd = wd; v.presp = presp; v.prd = prd;
    v.ex = ex; v.e_paddr = e_paddr; v.e_dat = e_dat; v.chk_dat = chk_dat; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic ok, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (!ok) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wait_resp(input string nm);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 16 && !seen; k++) begin
      @(negedge clk);
      seen = mem_resp;
    end
    chk(nm, seen, 256'(seen), 256'(1));
  endtask

  task automatic wait_pwr(input string nm);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 16 && !seen; k++) begin
      @(negedge clk);
      seen = pmem_write;
    end
    chk(nm, seen, 256'(seen), 256'(1));
  endtask

  initial begin
    vec_t v;
    logic ok;

    // write / drain
    vq.push_back(mk(WR, 32'h1040, 8'hA1, 1'b0, 8'h00, E0, 32'h0,    8'h00, 1'b0, 3'd0));
    vq.push_back(mk(WR, 32'h1040, 8'hA1, 1'b0, 8'h00, ER, 32'h0,    8'h00, 1'b0, 3'd1));
    vq.push_back(mk(NO, 32'h0,    8'h00, 1'b0, 8'h00, E0, 32'h0,    8'h00, 1'b0, 3'd1));
    vq.push_back(mk(NO, 32'h0,    8'h00, 1'b0, 8'h00, EW, 32'h1040, 8'hA1, 1'b0, 3'd1));
    vq.push_back(mk(NO, 32'h0,    8'h00, 1'b1, 8'h00, EW, 32'h1040, 8'hA1, 1'b0, 3'd1));
    vq.push_back(mk(NO, 32'h0,    8'h00, 1'b0, 8'h00, E0, 32'h0,    8'h00, 1'b0, 3'd0));
    // coalesce 0x100 / 0x11F
    vq.push_back(mk(WR, 32'h100,  8'h11, 1'b0, 8'h00, E0, 32'h0,    8'h00, 1'b0, 3'd0));
    vq.push_back(mk(WR, 32'h100,  8'h11, 1'b0, 8'h00, ER, 32'h0,    8'h00, 1'b0, 3'd1));
    vq.push_back(mk(WR, 32'h11F,  8'hB2, 1'b0, 8'h00, E0, 32'h0,    8'h00, 1'b0, 3'd1));
    vq.push_back(mk(WR, 32'h11F,  8'hB2, 1'b0, 8'h00, ER, 32'h0,    8'h00, 1'b0, 3'd1));
    vq.push_back(mk(NO, 32'h0,    8'h00, 1'b0, 8'h00, E0, 32'h0,    8'h00, 1'b0, 3'd1));
    vq.push_back(mk(NO, 32'h0,    8'h00, 1'b0, 8'h00, EW, 32'h100,  8'hB2, 1'b0, 3'd1));
    vq.push_back(mk(NO, 32'h0,    8'h00, 1'b0, 8'h00, EW, 32'h100,  8'hB2, 1'b0, 3'd1));
    vq.push_back(mk(NO, 32'h0,    8'h00, 1'b1, 8'h00, EW, 32'h100,  8'hB2, 1'b0, 3'd1));
    vq.push_back(mk(NO, 32'h0,    8'h00, 1'b0, 8'h00, E0, 32'h0,    8'h00, 1'b0, 3'd0));
    // read hit served from buffer
    vq.push_back(mk(WR, 32'h200,  8'hC3, 1'b0, 8'h00, E0, 32'h0,    8'h00, 1'b0, 3'd0));
    vq.push_back(mk(WR, 32'h200,  8'hC3, 1'b0, 8'h00, ER, 32'h0,    8'h00, 1'b0, 3'd1));
    vq.push_back(mk(RD, 32'h200,  8'h00, 1'b0, 8'h00, E0, 32'h0,    8'h00, 1'b0, 3'd1));
    vq.push_back(mk(RD, 32'h200,  8'h00, 1'b0, 8'h00, ER, 32'h0,    8'hC3, 1'b1, 3'd1));
    vq.push_back(mk(NO, 32'h0,    8'h00, 1'b0, 8'h00, E0, 32'h0,    8'h00, 1'b0, 3'd1));
    vq.push_back(mk(NO, 32'h0,    8'h00, 1'b1, 8'h00, EW, 32'h200,  8'hC3, 1'b0, 3'd1));
    vq.push_back(mk(NO, 32'h0,    8'h00, 1'b0, 8'h00, E0, 32'h0,    8'h00, 1'b0, 3'd0));
    // read miss with 3-cycle arbiter latency
    vq.push_back(mk(WR, 32'h300,  8'h33, 1'b0, 8'h00, E0, 32'h0,    8'h00, 1'b0, 3'd0));
    vq.push_back(mk(WR, 32'h300,  8'h33, 1'b0, 8'h00, ER, 32'h0,    8'h00, 1'b0, 3'd1));
    vq.push_back(mk(RD, 32'h400,  8'h00, 1'b0, 8'h00, E0, 32'h0,    8'h00, 1'b0, 3'd1));
    vq.push_back(mk(RD, 32'h400,  8'h00, 1'b0, 8'h00, EP, 32'h400,  8'h00, 1'b0, 3'd1));
    vq.push_back(mk(RD, 32'h400,  8'h00, 1'b0, 8'h00, EP, 32'h400,  8'h00, 1'b0, 3'd1));
    vq.push_back(mk(RD, 32'h400,  8'h00, 1'b1, 8'hD4, EP, 32'h400,  8'h00, 1'b0, 3'd1));
    vq.push_back(mk(RD, 32'h400,  8'h00, 1'b0, 8'h00, ER, 32'h0,    8'hD4, 1'b1, 3'd1));
    vq.push_back(mk(NO, 32'h0,    8'h00, 1'b0, 8'h00, E0, 32'h0,    8'h00, 1'b0, 3'd1));
    vq.push_back(mk(NO, 32'h0,    8'h00, 1'b0, 8'h00, EW, 32'h300,  8'h33, 1'b0, 3'd1));
    // reset during drain
    vq.push_back(mk(RS, 32'h0,    8'h00, 1'b0, 8'h00, EW, 32'h300,  8'h33, 1'b0, 3'd1));
    vq.push_back(mk(NO, 32'h0,    8'h00, 1'b0, 8'h00, E0, 32'h0,    8'h00, 1'b0, 3'd0));
    // fill to DEPTH, 5th write waits for a drain, then in-order drain across the wrap
    vq.push_back(mk(WR, 32'h500,  8'h50, 1'b0, 8'h00, E0, 32'h0,    8'h00, 1'b0, 3'd0));
    vq.push_back(mk(WR, 32'h500,  8'h50, 1'b0, 8'h00, ER, 32'h0,    8'h00, 1'b0, 3'd1));
    vq.push_back(mk(WR, 32'h520,  8'h52, 1'b0, 8'h00, E0, 32'h0,    8'h00, 1'b0, 3'd1));
    vq.push_back(mk(WR, 32'h520,  8'h52, 1'b0, 8'h00, ER, 32'h0,    8'h00, 1'b0, 3'd2));
    vq.push_back(mk(WR, 32'h540,  8'h54, 1'b0, 8'h00, E0, 32'h0,    8'h00, 1'b0, 3'd2));
    vq.push_back(mk(WR, 32'h540,  8'h54, 1'b0, 8'h00, ER, 32'h0,    8'h00, 1'b0, 3'd3));
    vq.push_back(mk(WR, 32'h560,  8'h56, 1'b0, 8'h00, E0, 32'h0,    8'h00, 1'b0, 3'd3));
    vq.push_back(mk(WR, 32'h560,  8'h56, 1'b0, 8'h00, ER, 32'h0,    8'h00, 1'b0, 3'd4));
    vq.push_back(mk(WR, 32'h580,  8'h58, 1'b0, 8'h00, E0, 32'h0,    8'h00, 1'b0, 3'd4));
    vq.push_back(mk(WR, 32'h580,  8'h58, 1'b0, 8'h00, EW, 32'h500,  8'h50, 1'b0, 3'd4));
    vq.push_back(mk(WR, 32'h580,  8'h58, 1'b0, 8'h00, EW, 32'h500,  8'h50, 1'b0, 3'd4));
    vq.push_back(mk(WR, 32'h580,  8'h58, 1'b1, 8'h00, EW, 32'h500,  8'h50, 1'b0, 3'd4));
    vq.push_back(mk(WR, 32'h580,  8'h58, 1'b0, 8'h00, E0, 32'h0,    8'h00, 1'b0, 3'd3));
    vq.push_back(mk(WR, 32'h580,  8'h58, 1'b0, 8'h00, ER, 32'h0,    8'h00, 1'b0, 3'd4));
    vq.push_back(mk(NO, 32'h0,    8'h00, 1'b0, 8'h00, E0, 32'h0,    8'h00, 1'b0, 3'd4));
    vq.push_back(mk(NO, 32'h0,    8'h00, 1'b1, 8'h00, EW, 32'h520,  8'h52, 1'b0, 3'd4));
    vq.push_back(mk(NO, 32'h0,    8'h00, 1'b0, 8'h00, E0, 32'h0,    8'h00, 1'b0, 3'd3));
    vq.push_back(mk(NO, 32'h0,    8'h00, 1'b1, 8'h00, EW, 32'h540,  8'h54, 1'b0, 3'd3));
    vq.push_back(mk(NO, 32'h0,    8'h00, 1'b0, 8'h00, E0, 32'h0,    8'h00, 1'b0, 3'd2));
    vq.push_back(mk(NO, 32'h0,    8'h00, 1'b1, 8'h00, EW, 32'h560,  8'h56, 1'b0, 3'd2));
    vq.push_back(mk(NO, 32'h0,    8'h00, 1'b0, 8'h00, E0, 32'h0,    8'h00, 1'b0, 3'd1));
    vq.push_back(mk(NO, 32'h0,    8'h00, 1'b1, 8'h00, EW, 32'h580,  8'h58, 1'b0, 3'd1));
    vq.push_back(mk(NO, 32'h0,    8'h00, 1'b0, 8'h00, E0, 32'h0,    8'h00, 1'b0, 3'd0));

    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_address = 32'h0;
    mem_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", {mem_resp, pmem_read, pmem_write, empty} === 4'b0001,
        256'({mem_resp, pmem_read, pmem_write, empty}), 256'(4'b0001));
    chk("reset_count", count === 3'd0, 256'(count), 256'(0));
    chk("reset_data", {pmem_address, pmem_wdata, mem_rdata} === '0,
        256'(pmem_address) ^ pmem_wdata ^ mem_rdata, 256'(0));

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      v  = vq[i];
      ok = ({mem_resp, pmem_read, pmem_write} === v.ex) && (count === v.e_cnt) &&
           (empty === (v.e_cnt == 3'd0));
      if (v.ex[1] || v.ex[0]) ok = ok && (pmem_address === v.e_paddr);
      if (v.ex[0]) ok = ok && (pmem_wdata === ln(v.e_dat));
      if (v.ex[2] && v.chk_dat) ok = ok && (mem_rdata === ln(v.e_dat));
      n_vec++;
      if (!ok) begin
        n_miss++;
        $display("FAIL vec %0d: got resp/rd/wr=%b cnt=%0d empty=%b paddr=%h wdata=%h rdata=%h; want resp/rd/wr=%b cnt=%0d paddr=%h data byte=%h",
                 i, {mem_resp, pmem_read, pmem_write}, count, empty, pmem_address, pmem_wdata[31:0],
                 mem_rdata[31:0], v.ex, v.e_cnt, v.e_paddr, v.e_dat);
      end
      rst         = v.ctl[2];
      mem_read    = v.ctl[1];
      mem_write   = v.ctl[0];
      mem_address = v.addr;
      mem_wdata   = ln(v.wd);
      pmem_resp   = v.presp;
      pmem_rdata  = ln(v.prd);
    end

    // Simultaneous read and write: the read is served first, the write afterwards.
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b1; mem_address = 32'h800; mem_wdata = ln(8'h99);
    @(negedge clk);
    chk("rw_fill_req", pmem_read === 1'b1 && pmem_write === 1'b0, 256'({pmem_read, pmem_write}), 256'(2'b10));
    chk("rw_fill_addr", pmem_address === 32'h800, 256'(pmem_address), 256'(32'h800));
    pmem_resp = 1'b1; pmem_rdata = ln(8'h88);
    wait_resp("rw_read_resp");
    pmem_resp = 1'b0;
    chk("rw_read_data", mem_rdata === ln(8'h88), mem_rdata, ln(8'h88));
    chk("rw_write_held", count === 3'd0, 256'(count), 256'(0));
    mem_read = 1'b0;
    wait_resp("rw_write_resp");
    chk("rw_write_count", count === 3'd1, 256'(count), 256'(1));
    mem_write = 1'b0;
    wait_pwr("rw_drain_start");
    chk("rw_drain_addr", pmem_address === 32'h800, 256'(pmem_address), 256'(32'h800));
    chk("rw_drain_data", pmem_wdata === ln(8'h99), pmem_wdata, ln(8'h99));
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    chk("rw_drain_done", count === 3'd0 && empty === 1'b1 && pmem_write === 1'b0,
        256'({count, empty, pmem_write}), 256'({3'd0, 1'b1, 1'b0}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
